eth_tx_frame_sender: RTL and testbench
======================================

Name: eth_tx_frame_sender

Overview:
- Single-clock frame source that drives the MAC's AXI-stream transmit input (tx_axis_*).
- Software or test logic writes one frame into an internal byte buffer, then issues a start command.
- Block then streams the frame byte-by-byte with full tvalid/tready handshake, tlast on final byte and tuser status.
- Sits in the logic_clk domain upstream of the MAC's TX FIFO.

Parameters:
- BUF_ADDR_WIDTH, 11, log2 of buffer depth in bytes (default 2048 bytes).
- LEN_WIDTH, BUF_ADDR_WIDTH+1, width of the frame-length command field.

Ports:
- logic_clk  input  1  block clock.
- logic_rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  buffer byte write strobe.
- wr_addr  input  BUF_ADDR_WIDTH  buffer byte address.
- wr_data  input  8  buffer write byte.
- start  input  1  start-transmit command pulse.
- start_len  input  LEN_WIDTH  frame length in bytes, sampled with start.
- busy  output  1  high from accepted start until final beat handshake.
- wr_err  output  1  one-cycle pulse: write or start rejected.
- frame_count  output  32  frames completed, wraps at 2^32.
- tx_axis_tdata  output  8  stream byte.
- tx_axis_tvalid  output  1  stream valid.
- tx_axis_tready  input  1  stream ready from MAC.
- tx_axis_tlast  output  1  final byte of frame.
- tx_axis_tuser  output  1  frame bad/abort flag, meaningful only with tlast.

Behaviour:
- Reset (asynchronous, logic_rst_n low): busy=0, wr_err=0, frame_count=0, tvalid=0, tlast=0, tuser=0, tdata=0; state IDLE. Buffer contents not reset.
- Reset mid-frame: tvalid drops immediately; no tlast is emitted; frame_count is not incremented.
- Reset release: outputs stay at reset values until a new start is accepted.
- States: IDLE -> LOAD -> SEND -> IDLE.
- IDLE, start=1, start_len>=1: latch len (saturate to 2^BUF_ADDR_WIDTH if larger), busy=1, go LOAD.
- IDLE, start=1, start_len=0: ignored, wr_err pulses.
- LOAD: one cycle to issue the first synchronous buffer read; go SEND.
- tvalid first asserts 2 cycles after the accepted start cycle.
- SEND: byte index i from 0 to len-1.
  - Handshake = tvalid & tready; i advances only on handshake.
  - tdata, tlast and tuser are held stable while tvalid=1 and tready=0.
  - Prefetch is mandatory: with tready held high, one byte is transferred per cycle with no bubbles.
  - tlast=1 exactly on byte len-1. A len=1 frame has tlast on its first beat.
  - On the final handshake: tvalid=0 next cycle, busy=0, frame_count+1, state IDLE.
  - A new start may be accepted on the cycle after busy falls.
- start while busy: ignored, wr_err pulses.
- wr_en while busy: write dropped, wr_err pulses; frame data is never corrupted mid-send.
- wr_en in IDLE: write stored.
- wr_en and start in the same IDLE cycle: write is applied first, start is accepted, and the frame includes the written byte.
- wr_err: one-cycle pulse per rejected event. Two simultaneous rejects (wr_en and start while busy) give a single pulse.
- tuser is 0 unless the optional feature is enabled.

Optional Feature:
- Macro: ETH_TX_SENDER_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 during SEND sets a sticky flag.
  - Frame then terminates on the next handshake: that beat carries tlast=1 and tuser=1.
  - Remaining bytes are skipped; frame_count still increments.
  - abort in IDLE or LOAD is ignored.
- Undefined: no abort port; tuser is tied to 0.

Test Plan:
- Write bytes 0x00..0x3B to addresses 0..59, start_len=60, tready=1 -> 60 consecutive beats, tdata=i, tlast only on beat 59, tuser=0, frame_count=1, busy low after final beat.
- Same frame with tready toggled 1/0 each cycle -> identical byte sequence; tdata/tlast stable during stall cycles; 60 handshakes total.
- start_len=0 -> no tvalid, wr_err one pulse. Start while busy -> wr_err pulse, current frame unaffected.
- start_len=1, byte 0xA5 -> single beat tdata=0xA5, tlast=1. start_len=4095 with BUF_ADDR_WIDTH=11 -> exactly 2048 beats.
- Assert logic_rst_n low at beat 20 of a 100-byte frame -> tvalid=0 immediately, frame_count=0, busy=0. Restart after release sends the full 100 bytes.
- ETH_TX_SENDER_ABORT_EN defined: abort at beat 10 with tready=1 -> beat 10 or 11 carries tlast=1 and tuser=1, no further beats, frame_count increments.

Source files
------------

// File: rtl/eth_tx_frame_sender.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eth_tx_frame_sender : buffered single-frame source for the MAC AXI-stream TX
// Optional abort input enabled by ETH_TX_SENDER_ABORT_EN.     Rev 1.0
// ----------------------------------------------------------------------------
module eth_tx_frame_sender #(
   parameter int BUF_ADDR_WIDTH = 11,
   parameter int LEN_WIDTH      = BUF_ADDR_WIDTH + 1
) (
   input  logic                      logic_clk,
   input  logic                      logic_rst_n,
   input  logic                      wr_en,
   input  logic [BUF_ADDR_WIDTH-1:0] wr_addr,
   input  logic [7:0]                wr_data,
   input  logic                      start,
   input  logic [LEN_WIDTH-1:0]      start_len,
`ifdef ETH_TX_SENDER_ABORT_EN
   input  logic                      abort,
`endif
   output logic                      busy,
   output logic                      wr_err,
   output logic [31:0]               frame_count,
   output logic [7:0]                tx_axis_tdata,
   output logic                      tx_axis_tvalid,
   input  logic                      tx_axis_tready,
   output logic                      tx_axis_tlast,
   output logic                      tx_axis_tuser
);

   localparam int                   DEPTH   = 1 << BUF_ADDR_WIDTH;
   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_ONE << BUF_ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [7:0]                mem [0:DEPTH-1];
   logic [7:0]                rd_q;
   logic [LEN_WIDTH-1:0]      len_q;
   logic [LEN_WIDTH-1:0]      idx_q;
   logic [LEN_WIDTH-1:0]      idx_nxt;
   logic                      tvalid_q;
   logic                      tlast_q;
   logic                      tuser_q;
   logic                      abort_pend_q;
   logic                      wr_err_q;
   logic [31:0]               frame_count_q;

   logic                      handshake;
   logic                      final_beat;
   logic                      accept;
   logic                      reject;
   logic                      wr_ok;
   logic                      abort_req;
   logic                      rd_en;
   logic [BUF_ADDR_WIDTH-1:0] rd_addr;

   assign busy       = (state != IDLE);
   assign handshake  = tvalid_q & tx_axis_tready;
   assign final_beat = handshake & tlast_q;
   assign accept     = (state == IDLE) & start & (start_len != '0);
   assign wr_ok      = (state == IDLE) & wr_en;
   assign reject     = (busy & (wr_en | start)) |
                       ((state == IDLE) & start & (start_len == '0));
   assign idx_nxt    = idx_q + LEN_ONE;

`ifdef ETH_TX_SENDER_ABORT_EN
   assign abort_req = (state == SEND) & abort;
`else
   assign abort_req = 1'b0;
`endif

   always_ff @(posedge logic_clk or negedge logic_rst_n) begin
      if (!logic_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Reads are issued only in LOAD or on a handshake, so rd_q holds the
   // presented byte stable across back-pressure.
   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      rd_addr   = '0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            rd_en     = 1'b1;
            state_nxt = SEND;
         end
         SEND: begin
            if (final_beat) begin
               state_nxt = IDLE;
            end else if (handshake) begin
               rd_en   = 1'b1;
               rd_addr = idx_nxt[BUF_ADDR_WIDTH-1:0];
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge logic_clk) begin
      if (wr_ok) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge logic_clk or negedge logic_rst_n) begin
      if (!logic_rst_n) begin
         rd_q <= '0;
      end else if (rd_en) begin
         rd_q <= mem[rd_addr];
      end
   end

   always_ff @(posedge logic_clk or negedge logic_rst_n) begin
      if (!logic_rst_n) begin
         len_q         <= '0;
         idx_q         <= '0;
         tvalid_q      <= 1'b0;
         tlast_q       <= 1'b0;
         tuser_q       <= 1'b0;
         abort_pend_q  <= 1'b0;
         wr_err_q      <= 1'b0;
         frame_count_q <= '0;
      end else begin
         wr_err_q <= reject;
         if (accept) begin
            len_q <= (start_len > MAX_LEN) ? MAX_LEN : start_len;
         end
         if (state == LOAD) begin
            tvalid_q     <= 1'b1;
            idx_q        <= '0;
            tlast_q      <= (len_q == LEN_ONE);
            tuser_q      <= 1'b0;
            abort_pend_q <= 1'b0;
         end else if (state == SEND) begin
            if (final_beat) begin
               tvalid_q      <= 1'b0;
               tlast_q       <= 1'b0;
               tuser_q       <= 1'b0;
               abort_pend_q  <= 1'b0;
               frame_count_q <= frame_count_q + 32'd1;
            end else begin
               if (abort_req) begin
                  abort_pend_q <= 1'b1;
               end
               // An abort cannot alter the beat already presented, so it
               // truncates the frame on the beat that follows.
               if (handshake) begin
                  idx_q <= idx_nxt;
                  if (abort_pend_q | abort_req) begin
                     tlast_q <= 1'b1;
                     tuser_q <= 1'b1;
                  end else begin
                     tlast_q <= (idx_nxt == (len_q - LEN_ONE));
                  end
               end
            end
         end
      end
   end

   assign wr_err         = wr_err_q;
   assign frame_count    = frame_count_q;
   assign tx_axis_tdata  = rd_q;
   assign tx_axis_tvalid = tvalid_q;
   assign tx_axis_tlast  = tlast_q;
   assign tx_axis_tuser  = tuser_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_frame_sender.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_eth_tx_frame_sender : directed self-checking bench for eth_tx_frame_sender
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_eth_tx_frame_sender;

   localparam int AW    = 11;
   localparam int LW    = AW + 1;
   localparam int DEPTH = 1 << AW;

   logic          logic_clk;
   logic          logic_rst_n;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          start;
   logic [LW-1:0] start_len;
`ifdef ETH_TX_SENDER_ABORT_EN
   logic          abort;
`endif
   logic          busy;
   logic          wr_err;
   logic [31:0]   frame_count;
   logic [7:0]    tx_axis_tdata;
   logic          tx_axis_tvalid;
   logic          tx_axis_tready;
   logic          tx_axis_tlast;
   logic          tx_axis_tuser;

   logic [7:0]    exp_mem [0:DEPTH-1];
   int            n_checks;
   int            n_errors;
   int            beats, cycles, data_err, ctl_err, stall_err;

   eth_tx_frame_sender #(.BUF_ADDR_WIDTH(AW)) dut (
      .logic_clk      (logic_clk),
      .logic_rst_n    (logic_rst_n),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .start          (start),
      .start_len      (start_len),
`ifdef ETH_TX_SENDER_ABORT_EN
      .abort          (abort),
`endif
      .busy           (busy),
      .wr_err         (wr_err),
      .frame_count    (frame_count),
      .tx_axis_tdata  (tx_axis_tdata),
      .tx_axis_tvalid (tx_axis_tvalid),
      .tx_axis_tready (tx_axis_tready),
      .tx_axis_tlast  (tx_axis_tlast),
      .tx_axis_tuser  (tx_axis_tuser)
   );

   initial logic_clk = 1'b0;
   always #5 logic_clk = ~logic_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge logic_clk);
      #1;
   endtask

   task automatic write_byte(input int a, input logic [7:0] d);
      wr_en      = 1'b1;
      wr_addr    = AW'(a);
      wr_data    = d;
      exp_mem[a] = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic start_cmd(input int len);
      start     = 1'b1;
      start_len = LW'(len);
      step();
      start = 1'b0;
   endtask

   // Drives tready, collects beats until tlast, and tallies data, control
   // and hold-during-stall discrepancies against the bench's buffer image.
   task automatic stream(input int exp_beats, input bit toggle,
                         output int o_beats, output int o_cycles,
                         output int o_data_err, output int o_ctl_err,
                         output int o_stall_err);
      logic [7:0] prev_data;
      logic       prev_last;
      bit         stalled;
      bit         done;
      o_beats = 0; o_cycles = 0; o_data_err = 0; o_ctl_err = 0; o_stall_err = 0;
      prev_data = '0; prev_last = 1'b0; stalled = 1'b0; done = 1'b0;
      while (!done && o_cycles < 3 * exp_beats + 20) begin
         tx_axis_tready = toggle ? ((o_cycles % 2) == 0) : 1'b1;
         if (stalled && (tx_axis_tdata !== prev_data || tx_axis_tlast !== prev_last))
            o_stall_err++;
         if (tx_axis_tvalid && tx_axis_tready) begin
            if (tx_axis_tdata !== exp_mem[o_beats % DEPTH]) o_data_err++;
            if (tx_axis_tlast !== (o_beats == exp_beats - 1) || tx_axis_tuser !== 1'b0)
               o_ctl_err++;
            o_beats++;
            if (tx_axis_tlast === 1'b1) done = 1'b1;
         end
         stalled   = tx_axis_tvalid && !tx_axis_tready;
         prev_data = tx_axis_tdata;
         prev_last = tx_axis_tlast;
         o_cycles++;
         step();
      end
      tx_axis_tready = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      logic_rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; start_len = '0; tx_axis_tready = 1'b0;
`ifdef ETH_TX_SENDER_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) step();
      check("rst_busy",   busy, 0);
      check("rst_wr_err", wr_err, 0);
      check("rst_fcount", frame_count, 0);
      check("rst_tvalid", tx_axis_tvalid, 0);
      check("rst_tlast",  tx_axis_tlast, 0);
      check("rst_tuser",  tx_axis_tuser, 0);
      check("rst_tdata",  tx_axis_tdata, 0);
      logic_rst_n = 1'b1;
      step();

      // 60-byte counting frame, tready held high
      for (int i = 0; i < 60; i++) write_byte(i, 8'(i));
      start_cmd(60);
      check("load_tvalid", tx_axis_tvalid, 0);
      check("load_busy", busy, 1);
      step();
      check("first_tvalid", tx_axis_tvalid, 1);
      stream(60, 1'b0, beats, cycles, data_err, ctl_err, stall_err);
      check("f1_beats", beats, 60);
      check("f1_cycles", cycles, 60);
      check("f1_data", data_err, 0);
      check("f1_ctl", ctl_err, 0);
      check("f1_tvalid_after", tx_axis_tvalid, 0);
      check("f1_busy_after", busy, 0);
      check("f1_fcount", frame_count, 1);

      // same frame with tready toggling
      start_cmd(60);
      step();
      stream(60, 1'b1, beats, cycles, data_err, ctl_err, stall_err);
      check("f2_beats", beats, 60);
      check("f2_cycles", cycles, 119);
      check("f2_data", data_err, 0);
      check("f2_ctl", ctl_err, 0);
      check("f2_stall_hold", stall_err, 0);
      check("f2_fcount", frame_count, 2);

      // zero-length start is rejected
      start_cmd(0);
      check("len0_wr_err", wr_err, 1);
      check("len0_busy", busy, 0);
      step();
      check("len0_wr_err_clr", wr_err, 0);
      check("len0_tvalid", tx_axis_tvalid, 0);

      // start and write while busy: one error pulse, frame untouched
      start_cmd(60);
      start = 1'b1; start_len = LW'(5);
      wr_en = 1'b1; wr_addr = '0; wr_data = 8'hFF;
      step();
      start = 1'b0; wr_en = 1'b0;
      check("busy_wr_err", wr_err, 1);
      step();
      check("busy_wr_err_clr", wr_err, 0);
      stream(60, 1'b0, beats, cycles, data_err, ctl_err, stall_err);
      check("f3_beats", beats, 60);
      check("f3_data", data_err, 0);
      check("f3_ctl", ctl_err, 0);
      check("f3_fcount", frame_count, 3);

      // single-byte frame, written in the same cycle as the start
      wr_en = 1'b1; wr_addr = '0; wr_data = 8'hA5; exp_mem[0] = 8'hA5;
      start = 1'b1; start_len = LW'(1);
      step();
      wr_en = 1'b0; start = 1'b0;
      step();
      check("len1_tdata", tx_axis_tdata, 8'hA5);
      check("len1_tlast", tx_axis_tlast, 1);
      stream(1, 1'b0, beats, cycles, data_err, ctl_err, stall_err);
      check("len1_beats", beats, 1);
      check("len1_data", data_err, 0);
      check("len1_ctl", ctl_err, 0);
      check("len1_fcount", frame_count, 4);

      // oversize length saturates to the full buffer
      for (int a = 0; a < DEPTH; a++) write_byte(a, 8'(a * 7 + 3));
      start_cmd(4095);
      step();
      stream(DEPTH, 1'b0, beats, cycles, data_err, ctl_err, stall_err);
      check("sat_beats", beats, 2048);
      check("sat_cycles", cycles, 2048);
      check("sat_data", data_err, 0);
      check("sat_ctl", ctl_err, 0);
      check("sat_fcount", frame_count, 5);

      // reset at beat 20 of a 100-byte frame, then resend
      for (int i = 0; i < 100; i++) write_byte(i, 8'(i ^ 8'h5A));
      start_cmd(100);
      step();
      tx_axis_tready = 1'b1;
      repeat (20) step();
      check("pre_rst_tdata", tx_axis_tdata, 8'(20 ^ 8'h5A));
      logic_rst_n = 1'b0;
      #1;
      check("mid_rst_tvalid", tx_axis_tvalid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_fcount", frame_count, 0);
      tx_axis_tready = 1'b0;
      step();
      logic_rst_n = 1'b1;
      step();
      check("post_rst_tvalid", tx_axis_tvalid, 0);
      start_cmd(100);
      step();
      stream(100, 1'b0, beats, cycles, data_err, ctl_err, stall_err);
      check("rst_resend_beats", beats, 100);
      check("rst_resend_data", data_err, 0);
      check("rst_resend_ctl", ctl_err, 0);
      check("rst_resend_fcount", frame_count, 1);

`ifdef ETH_TX_SENDER_ABORT_EN
      begin
         int  hs;
         int  last_idx;
         bit  last_user;
         bit  fin;
         hs = 0; last_idx = -1; last_user = 1'b0; fin = 1'b0;
         start_cmd(30);
         step();
         tx_axis_tready = 1'b1;
         repeat (10) step();
         hs = 10;
         abort = 1'b1;
         for (int k = 0; k < 40 && !fin; k++) begin
            if (tx_axis_tvalid && tx_axis_tlast) begin
               last_idx  = hs;
               last_user = tx_axis_tuser;
               fin       = 1'b1;
            end
            if (tx_axis_tvalid) hs++;
            step();
            abort = 1'b0;
         end
         tx_axis_tready = 1'b0;
         check("abort_last_beat_ok", (last_idx == 10 || last_idx == 11), 1);
         check("abort_tuser", last_user, 1);
         check("abort_tvalid_after", tx_axis_tvalid, 0);
         check("abort_fcount", frame_count, 2);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
